// File: rtl/trex_pkg.sv
// Shared T-rex geometry: collision box layout and the number of T-rex boxes.
package trex_pkg;
  localparam int COLLISION_BOX_COUNT = 6;

  typedef struct packed {
    logic [11:0] x;  // two's complement
    logic [11:0] y;  // two's complement
    logic [9:0]  w;
    logic [9:0]  h;
  } collision_box_t;
endpackage

// File: rtl/collision_checker.sv
// Snapshots T-rex/obstacle boxes on each frame update and scans coarse bbox then fine box pairs.
// Define COLLISION_CHECKER_LIVES_EN to absorb the first hits as cracks before crashing.
module collision_checker
  import trex_pkg::*;
#(
  parameter int OBSTACLE_COUNT = 3,
  parameter int OBS_BOX_COUNT  = 3,
`ifdef COLLISION_CHECKER_LIVES_EN
  parameter int INITIAL_LIVES  = 3,
`endif
  parameter int TREX_BOX_COUNT = COLLISION_BOX_COUNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic                  immune,
  input  logic signed [11:0]    trex_x_pos,
  input  logic signed [11:0]    trex_y_pos,
  input  logic [9:0]            trex_width,
  input  logic [9:0]            trex_height,
  input  collision_box_t        trex_box [TREX_BOX_COUNT],
  input  logic [OBSTACLE_COUNT-1:0] obs_valid,
  input  collision_box_t        obs_bbox [OBSTACLE_COUNT],
  input  collision_box_t        obs_box  [OBSTACLE_COUNT][OBS_BOX_COUNT],
  output logic                  busy,
  output logic                  done,
  output logic                  crash,
  output logic                  crack,
  output logic [((OBSTACLE_COUNT > 1) ? $clog2(OBSTACLE_COUNT) : 1)-1:0] hit_index,
  output logic                  overrun,
  output logic [1:0]            lives
);
  localparam int IW = (OBSTACLE_COUNT > 1) ? $clog2(OBSTACLE_COUNT) : 1;
  localparam int TW = (TREX_BOX_COUNT > 1) ? $clog2(TREX_BOX_COUNT) : 1;
  localparam int OW = (OBS_BOX_COUNT > 1) ? $clog2(OBS_BOX_COUNT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(OBSTACLE_COUNT - 1);
  localparam logic [TW-1:0] LAST_T   = TW'(TREX_BOX_COUNT - 1);
  localparam logic [OW-1:0] LAST_O   = OW'(OBS_BOX_COUNT - 1);

  typedef enum logic [1:0] {IDLE, COARSE, FINE, REPORT} state_t;
  state_t state, state_nxt;

  collision_box_t            trex_bbox_s;
  collision_box_t            trex_box_s [TREX_BOX_COUNT];
  logic [OBSTACLE_COUNT-1:0] obs_valid_s;
  collision_box_t            obs_bbox_s [OBSTACLE_COUNT];
  collision_box_t            obs_box_s  [OBSTACLE_COUNT][OBS_BOX_COUNT];

  logic [IW-1:0] idx;
  logic [TW-1:0] t_idx;
  logic [OW-1:0] o_idx;
  logic          hit;
  logic [IW-1:0] hit_slot;
  logic          coarse_ov;
  logic          fine_ov;

  // Strict overlap: touching edges do not count. 13 bits hold any coordinate + width.
  function automatic logic overlap(input collision_box_t a, input collision_box_t b);
    logic signed [12:0] ax, ay, bx, by;
    ax = {a.x[11], a.x};
    ay = {a.y[11], a.y};
    bx = {b.x[11], b.x};
    by = {b.y[11], b.y};
    return (ax < bx + $signed({3'b000, b.w})) && (bx < ax + $signed({3'b000, a.w})) &&
           (ay < by + $signed({3'b000, b.h})) && (by < ay + $signed({3'b000, a.h}));
  endfunction

  assign coarse_ov = obs_valid_s[idx] && overlap(trex_bbox_s, obs_bbox_s[idx]);
  assign fine_ov   = overlap(trex_box_s[t_idx], obs_box_s[idx][o_idx]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (update) begin
      state_nxt = (immune || crash) ? REPORT : COARSE;
    end else begin
      case (state)
        IDLE: ;
        COARSE:
          if (coarse_ov)             state_nxt = FINE;
          else if (idx == LAST_IDX)  state_nxt = REPORT;
        FINE:
          if (fine_ov)                                      state_nxt = REPORT;
          else if (t_idx == LAST_T && o_idx == LAST_O)      state_nxt = (idx == LAST_IDX) ? REPORT : COARSE;
        REPORT: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (update) begin
      trex_bbox_s.x <= trex_x_pos;
      trex_bbox_s.y <= trex_y_pos;
      trex_bbox_s.w <= trex_width;
      trex_bbox_s.h <= trex_height;
      trex_box_s    <= trex_box;
      obs_valid_s   <= obs_valid;
      obs_bbox_s    <= obs_bbox;
      obs_box_s     <= obs_box;
    end
  end

`ifdef COLLISION_CHECKER_LIVES_EN
  logic [1:0] lives_q;
  assign lives = lives_q;
`else
  assign lives = 2'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      crash     <= 1'b0;
      crack     <= 1'b0;
      hit_index <= '0;
      overrun   <= 1'b0;
      idx       <= '0;
      t_idx     <= '0;
      o_idx     <= '0;
      hit       <= 1'b0;
      hit_slot  <= '0;
`ifdef COLLISION_CHECKER_LIVES_EN
      lives_q   <= 2'(INITIAL_LIVES);
`endif
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      if (update) begin
        // A restart throws away any partial scan result.
        busy    <= 1'b1;
        crack   <= 1'b0;
        overrun <= (state != IDLE);
        idx     <= '0;
        t_idx   <= '0;
        o_idx   <= '0;
        hit     <= 1'b0;
      end else begin
        case (state)
          COARSE:
            if (!coarse_ov && idx != LAST_IDX) idx <= idx + IW'(1);
          FINE:
            if (fine_ov) begin
              hit      <= 1'b1;
              hit_slot <= idx;
            end else if (o_idx == LAST_O) begin
              o_idx <= '0;
              if (t_idx == LAST_T) begin
                t_idx <= '0;
                if (idx != LAST_IDX) idx <= idx + IW'(1);
              end else begin
                t_idx <= t_idx + TW'(1);
              end
            end else begin
              o_idx <= o_idx + OW'(1);
            end
          REPORT: begin
            done <= 1'b1;
            busy <= 1'b0;
            if (hit) begin
              hit_index <= hit_slot;
`ifdef COLLISION_CHECKER_LIVES_EN
              if (lives_q != 2'd0) begin
                crack   <= 1'b1;
                lives_q <= lives_q - 2'd1;
              end else begin
                crash   <= 1'b1;
              end
`else
              crash <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
